// File: rtl/accel_emulator_mc.sv
// -----------------------------------------------------------------------------
// accel_emulator_mc
//   Multi-channel accelerator emulator. It stands in for real accelerator cores
//   during bring-up. Each channel takes a start pulse and a per-job latency,
//   counts down, and then reports completion. Completion is a one-cycle pulse
//   when FINISH_MODE=0. When FINISH_MODE=1 it is a level held until
//   acknowledged. A job can be aborted, a start that arrives while the channel
//   is busy raises a sticky overrun flag, and a shared 32-bit counter totals
//   the completed jobs.
//
// Ports
//   clk             clock
//   aresetn         asynchronous active-low reset
//   acc_start       per-channel job start
//   acc_latency     per-channel latency; channel i uses [i*CNT_W +: CNT_W],
//                   and 0 selects DEFAULT_LAT
//   acc_abort       per-channel abort (overrides start and ack)
//   acc_finish_ack  per-channel finish acknowledge (FINISH_MODE=1 only)
//   acc_finish      per-channel job complete
//   acc_busy        per-channel busy (RUN or DONE)
//   acc_err_overrun per-channel sticky overrun flag
//   done_count      total completed jobs, wraps modulo 2^32
// -----------------------------------------------------------------------------
module accel_emulator_mc #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_LAT = 100,
   parameter int FINISH_MODE = 0
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic [NUM_CH-1:0]       acc_start,
   input  logic [NUM_CH*CNT_W-1:0] acc_latency,
   input  logic [NUM_CH-1:0]       acc_abort,
   input  logic [NUM_CH-1:0]       acc_finish_ack,
   output logic [NUM_CH-1:0]       acc_finish,
   output logic [NUM_CH-1:0]       acc_busy,
   output logic [NUM_CH-1:0]       acc_err_overrun,
   output logic [31:0]             done_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] DEF_LAT = CNT_W'(DEFAULT_LAT);

   state_t            state_q [NUM_CH];
   state_t            state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] finish_q, finish_d;
   logic [NUM_CH-1:0] busy_q, busy_d;
   logic [NUM_CH-1:0] err_q, err_d;
   logic [31:0]       done_count_q, done_count_d;
   logic [31:0]       done_inc;
   logic [CNT_W-1:0]  lat_v;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         finish_q     <= '0;
         busy_q       <= '0;
         err_q        <= '0;
         done_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         finish_q     <= finish_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         done_count_q <= done_count_d;
      end
   end

   always_comb begin
      done_inc = '0;
      lat_v    = '0;
      finish_d = finish_q;
      busy_d   = busy_q;
      err_d    = err_q;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         // A start seen outside IDLE is dropped but recorded, including one
         // that coincides with an abort.
         if (acc_start[i] && (state_q[i] != S_IDLE))
            err_d[i] = 1'b1;
         unique case (state_q[i])
            S_IDLE: begin
               lat_v = acc_latency[i*CNT_W +: CNT_W];
               // Abort beats a simultaneous start: no job, no error.
               if (acc_start[i] && !acc_abort[i]) begin
                  cnt_d[i]   = (lat_v == '0) ? DEF_LAT : lat_v;
                  busy_d[i]  = 1'b1;
                  state_d[i] = S_RUN;
               end
            end
            S_RUN: begin
               if (acc_abort[i]) begin
                  cnt_d[i]   = '0;
                  busy_d[i]  = 1'b0;
                  state_d[i] = S_IDLE;
               end else if (cnt_q[i] == CNT_W'(1)) begin
                  // cnt holds the cycles still owed including this edge, so
                  // finish appears exactly L edges after the start.
                  cnt_d[i]    = '0;
                  finish_d[i] = 1'b1;
                  state_d[i]  = S_DONE;
                  done_inc    = done_inc + 32'd1;
               end else begin
                  cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
            end
            S_DONE: begin
               if ((FINISH_MODE == 0) || acc_finish_ack[i] || acc_abort[i]) begin
                  finish_d[i] = 1'b0;
                  busy_d[i]   = 1'b0;
                  state_d[i]  = S_IDLE;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
            end
         endcase
      end
      // The counter wraps freely; simultaneous completions all count.
      done_count_d = done_count_q + done_inc;
   end

   assign acc_finish      = finish_q;
   assign acc_busy        = busy_q;
   assign acc_err_overrun = err_q;
   assign done_count      = done_count_q;

endmodule
